transmissor_estado_jogo: RTL

- Serial transmitter that reports game state from the astro_genius top level to an external host (PC/display) over a UART-style 8N1 line.
- On a request pulse it snapshots the asteroid coordinates, the life count and the event flags (tiro, colisao, acertou, perdeu), then sends them as a fixed 3-byte frame.
- The host-side receiver decodes this frame. This block is the outbound end of the game's I/O, complementary to the jogada input path.

---
 rtl/transmissor_estado_jogo_pkg.sv | 40 ++++
 rtl/transmissor_estado_jogo_serializador_8n1.sv | 62 ++++++
 rtl/transmissor_estado_jogo.sv | 115 +++++++++++
 3 files changed

// File: rtl/transmissor_estado_jogo_pkg.sv
// Shared definitions for the game-state serial transmitter.
// - estado_t        : FSM state encoding, 4 bits wide so it can drive db_estado directly.
// - CABECALHO_PADRAO: default header byte that opens every frame.
// - FRAME_BYTES     : number of bytes in a frame.
// - BITS_POR_BYTE   : bits on the line per byte (start + 8 data + stop).
// - monta_byte      : selects the byte sent at a given frame index.
package transmissor_estado_jogo_pkg;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    CARREGA      = 4'd1,
    TRANSMITE    = 4'd2,
    PROXIMO_BYTE = 4'd3,
    FINAL        = 4'd4
  } estado_t;

  localparam logic [7:0] CABECALHO_PADRAO = 8'hA5;
  localparam int         FRAME_BYTES      = 3;
  localparam int         BITS_POR_BYTE    = 10;

  // Byte 0 is the header, byte 1 packs the coordinates and byte 2 packs
  // the event flags over the life count. Values are sent raw.
  function automatic logic [7:0] monta_byte(
    input logic [1:0] indice,
    input logic [7:0] cab,
    input logic [3:0] x,
    input logic [3:0] y,
    input logic [3:0] vidas,
    input logic [3:0] flags
  );
    logic [7:0] r;
    case (indice)
      2'd0:    r = cab;
      2'd1:    r = {y, x};
      default: r = {flags, vidas};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/transmissor_estado_jogo_serializador_8n1.sv
// 8N1 byte serializer.
// - clock, reset  : system clock, asynchronous active-high reset.
// - carregar      : loads dado into the shift register and starts a byte.
// - dado[7:0]     : byte to send, LSB first.
// - saida_serial  : serial line, high when no byte is active.
// - fim_byte      : high during the second-to-last cycle of the stop bit, so
//                   the parent can spend the last stop cycle loading the next
//                   byte without stretching the bit.
module transmissor_estado_jogo_serializador_8n1
  import transmissor_estado_jogo_pkg::*;
#(
  parameter int CICLOS_POR_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       carregar,
  input  logic [7:0] dado,
  output logic       saida_serial,
  output logic       fim_byte
);

  localparam int             TW       = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [TW-1:0]  TICK_FIM = TW'(CICLOS_POR_BIT - 1);
  localparam logic [TW-1:0]  TICK_PRE = TW'(CICLOS_POR_BIT - 2);
  localparam logic [3:0]     BIT_FIM  = 4'(BITS_POR_BYTE - 1);

  logic [BITS_POR_BYTE-1:0] r_desloc;
  logic [TW-1:0]            r_tick;
  logic [3:0]               r_bit;
  logic                     r_ativo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_desloc <= '0;
      r_tick   <= '0;
      r_bit    <= '0;
      r_ativo  <= 1'b0;
    end else if (carregar) begin
      r_desloc <= {1'b1, dado, 1'b0};
      r_tick   <= '0;
      r_bit    <= '0;
      r_ativo  <= 1'b1;
    end else if (r_ativo) begin
      if (r_tick == TICK_FIM) begin
        r_tick   <= '0;
        r_desloc <= {1'b1, r_desloc[BITS_POR_BYTE-1:1]};
        if (r_bit == BIT_FIM) begin
          r_bit   <= '0;
          r_ativo <= 1'b0;
        end else begin
          r_bit <= r_bit + 4'd1;
        end
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

  assign saida_serial = r_ativo ? r_desloc[0] : 1'b1;
  assign fim_byte     = r_ativo && (r_bit == BIT_FIM) && (r_tick == TICK_PRE);

endmodule

// File: rtl/transmissor_estado_jogo.sv
// Game-state transmitter: on enviar, snapshots the asteroid position, life
// count and event flags and sends them as a 3-byte 8N1 frame
// (header, {y,x}, {perdeu,acertou,colisao,tiro,vidas}).
// - clock, reset           : system clock, asynchronous active-high reset.
// - enviar                 : send request, honoured only when idle.
// - asteroide_x/y, vidas   : 4-bit values captured at the request.
// - tiro/colisao/acertou/perdeu : event flags captured at the request.
// - saida_serial           : serial line, idle high.
// - ocupado                : a frame is in progress.
// - pronto                 : one-cycle pulse right after the last stop bit.
// - db_estado              : current FSM state code.
module transmissor_estado_jogo
  import transmissor_estado_jogo_pkg::*;
#(
  parameter int         CICLOS_POR_BIT = 434,
  parameter logic [7:0] CABECALHO      = CABECALHO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enviar,
  input  logic [3:0] asteroide_x,
  input  logic [3:0] asteroide_y,
  input  logic [3:0] vidas,
  input  logic       tiro,
  input  logic       colisao,
  input  logic       acertou,
  input  logic       perdeu,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t    r_estado, w_prox;
  logic [1:0] r_indice, w_indice_carga;
  logic [3:0] r_x, r_y, r_vidas, r_flags;
  logic       r_iniciar;
  logic       w_carregar, w_serial, w_fim_byte, w_ultimo;
  logic [7:0] w_dado;

  assign w_ultimo = (r_indice == 2'(FRAME_BYTES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_indice  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_vidas   <= '0;
      r_flags   <= '0;
      r_iniciar <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      // First byte is launched one cycle into TRANSMITE, which puts the
      // start bit two edges after the capture edge.
      r_iniciar <= (r_estado == CARREGA);
      if (r_estado == OCIOSO && enviar) begin
        r_x     <= asteroide_x;
        r_y     <= asteroide_y;
        r_vidas <= vidas;
        r_flags <= {perdeu, acertou, colisao, tiro};
      end
      if (r_estado == CARREGA) begin
        r_indice <= '0;
      end else if (r_estado == PROXIMO_BYTE && !w_ultimo) begin
        r_indice <= r_indice + 2'd1;
      end
    end
  end

  always_comb begin
    w_prox     = r_estado;
    w_carregar = 1'b0;
    case (r_estado)
      OCIOSO:       if (enviar) w_prox = CARREGA;
      CARREGA:      w_prox = TRANSMITE;
      TRANSMITE: begin
        w_carregar = r_iniciar;
        if (w_fim_byte) w_prox = PROXIMO_BYTE;
      end
      // This cycle is the last cycle of the stop bit; loading here makes
      // the next start bit follow with no gap.
      PROXIMO_BYTE: begin
        if (w_ultimo) begin
          w_prox = FINAL;
        end else begin
          w_carregar = 1'b1;
          w_prox     = TRANSMITE;
        end
      end
      FINAL:        w_prox = OCIOSO;
      default:      w_prox = OCIOSO;
    endcase
  end

  assign w_indice_carga = (r_estado == PROXIMO_BYTE) ? 2'(r_indice + 2'd1) : r_indice;
  assign w_dado = monta_byte(w_indice_carga, CABECALHO, r_x, r_y, r_vidas, r_flags);

  transmissor_estado_jogo_serializador_8n1 #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) u_serializador (
    .clock        (clock),
    .reset        (reset),
    .carregar     (w_carregar),
    .dado         (w_dado),
    .saida_serial (w_serial),
    .fim_byte     (w_fim_byte)
  );

  assign saida_serial = (r_estado == TRANSMITE || r_estado == PROXIMO_BYTE) ? w_serial : 1'b1;
  assign ocupado      = (r_estado != OCIOSO);
  assign pronto       = (r_estado == FINAL);
  assign db_estado    = r_estado;

endmodule
